// File: rtl/gir_wb_ctrl.sv
// Write-back controller for the integer register file: merges ALU results and
// in-order LSU load responses onto one write port and tracks pending loads.
module gir_wb_ctrl #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_req_valid,
  input  logic [4:0]               lsu_req_rd,
  output logic                     lsu_req_ready,
  input  logic                     lsu_resp_valid,
  input  logic [XLEN-1:0]          lsu_resp_data,
  output logic                     lsu_resp_ready,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic [4:0]               rd,
  output logic                     rd_wen,
  output logic [XLEN-1:0]          x_rd,
  output logic [$clog2(DEPTH):0]   lsu_outstanding,
  output logic                     wb_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]    tag_q [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;

  logic          full;
  logic          empty;
  logic          alu_wr;
  logic          push;
  logic          pop;
  logic [4:0]    head_rd;

  // Queue status and handshakes; ALU writes to x0 do not count as traffic.
  always_comb begin
    full           = (count == CW'(DEPTH));
    empty          = (count == '0);
    alu_wr         = alu_valid & (alu_rd != 5'd0);
    head_rd        = tag_q[rd_ptr];
    lsu_req_ready  = ~full & ~busy[lsu_req_rd];
    lsu_resp_ready = ~empty & ~alu_wr;
    push           = lsu_req_valid & lsu_req_ready;
    pop            = lsu_resp_valid & lsu_resp_ready;
    rs1_busy       = busy[rs1];
    rs2_busy       = busy[rs2];
    lsu_outstanding = count;
  end

  // Clear lands with the register-file write; a new reservation wins over it.
  always_comb begin
    busy_nxt = busy;
    if (rd_wen) begin
      busy_nxt[rd] = 1'b0;
    end
    if (push && (lsu_req_rd != 5'd0)) begin
      busy_nxt[lsu_req_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Tag storage needs no reset; validity is carried by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[wr_ptr] <= lsu_req_rd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= '0;
    end else begin
      busy <= busy_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; loads targeting x0 are drained without a write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd     <= '0;
      rd_wen <= 1'b0;
      x_rd   <= '0;
    end else begin
      rd_wen <= 1'b0;
      if (alu_wr) begin
        rd     <= alu_rd;
        x_rd   <= alu_data;
        rd_wen <= 1'b1;
      end else if (pop && (head_rd != 5'd0)) begin
        rd     <= head_rd;
        x_rd   <= lsu_resp_data;
        rd_wen <= 1'b1;
      end
    end
  end

  // Sticky protocol errors: orphan response, or ALU overwriting a pending load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_err <= 1'b0;
    end else if ((lsu_resp_valid && empty) || (alu_wr && busy[alu_rd])) begin
      wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gir_wb_ctrl.sv
// Directed bench for gir_wb_ctrl: ALU/LSU write-back, arbitration, scoreboard,
// queue full/WAW stalls, x0 loads, error flag and async reset.
module tb_gir_wb_ctrl;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_req_valid;
  logic [4:0]      lsu_req_rd;
  logic            lsu_req_ready;
  logic            lsu_resp_valid;
  logic [XLEN-1:0] lsu_resp_data;
  logic            lsu_resp_ready;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [4:0]      rd;
  logic            rd_wen;
  logic [XLEN-1:0] x_rd;
  logic [2:0]      lsu_outstanding;
  logic            wb_err;

  int checks = 0;
  int errors = 0;

  gir_wb_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_rd     (lsu_req_rd),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_data  (lsu_resp_data),
    .lsu_resp_ready (lsu_resp_ready),
    .rs1            (rs1),
    .rs2            (rs2),
    .rs1_busy       (rs1_busy),
    .rs2_busy       (rs2_busy),
    .rd             (rd),
    .rd_wen         (rd_wen),
    .x_rd           (x_rd),
    .lsu_outstanding(lsu_outstanding),
    .wb_err         (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_req_valid = 1'b0; lsu_req_rd = '0;
    lsu_resp_valid = 1'b0; lsu_resp_data = '0;
    rs1 = '0; rs2 = '0;

    // Reset state
    #12;
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_wen", 64'(rd_wen), 64'd0);
    chk("rst_xrd", x_rd, 64'd0);
    chk("rst_outst", 64'(lsu_outstanding), 64'd0);
    chk("rst_err", 64'(wb_err), 64'd0);
    chk("rst_resp_rdy", 64'(lsu_resp_ready), 64'd0);
    chk("rst_req_rdy", 64'(lsu_req_ready), 64'd1);
    tick();
    rst = 1'b1;
    tick();

    // ALU write to x5
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
    tick();
    alu_valid = 1'b0;
    chk("alu_rd", 64'(rd), 64'd5);
    chk("alu_xrd", x_rd, 64'h1234);
    chk("alu_wen", 64'(rd_wen), 64'd1);
    tick();
    chk("alu_wen_off", 64'(rd_wen), 64'd0);
    chk("alu_rd_hold", 64'(rd), 64'd5);

    // Single load to x7
    lsu_req_valid = 1'b1; lsu_req_rd = 5'd7;
    settle();
    chk("ld7_req_rdy", 64'(lsu_req_ready), 64'd1);
    tick();
    lsu_req_valid = 1'b0;
    rs1 = 5'd7; rs2 = 5'd7;
    settle();
    chk("ld7_rs1_busy", 64'(rs1_busy), 64'd1);
    chk("ld7_rs2_busy", 64'(rs2_busy), 64'd1);
    chk("ld7_outst", 64'(lsu_outstanding), 64'd1);
    lsu_resp_valid = 1'b1; lsu_resp_data = 64'hDEAD;
    settle();
    chk("ld7_resp_rdy", 64'(lsu_resp_ready), 64'd1);
    tick();
    lsu_resp_valid = 1'b0;
    chk("ld7_rd", 64'(rd), 64'd7);
    chk("ld7_xrd", x_rd, 64'hDEAD);
    chk("ld7_wen", 64'(rd_wen), 64'd1);
    chk("ld7_outst0", 64'(lsu_outstanding), 64'd0);
    chk("ld7_busy_still", 64'(rs1_busy), 64'd1);
    tick();
    chk("ld7_busy_clr", 64'(rs1_busy), 64'd0);

    // ALU and LSU response collide; ALU goes first
    lsu_req_valid = 1'b1; lsu_req_rd = 5'd7;
    tick();
    lsu_req_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 64'h33;
    lsu_resp_valid = 1'b1; lsu_resp_data = 64'h77;
    settle();
    chk("arb_resp_blk", 64'(lsu_resp_ready), 64'd0);
    tick();
    alu_valid = 1'b0;
    chk("arb_rd3", 64'(rd), 64'd3);
    chk("arb_x3", x_rd, 64'h33);
    settle();
    chk("arb_resp_rdy", 64'(lsu_resp_ready), 64'd1);
    tick();
    lsu_resp_valid = 1'b0;
    chk("arb_rd7", 64'(rd), 64'd7);
    chk("arb_x7", x_rd, 64'h77);
    chk("arb_wen7", 64'(rd_wen), 64'd1);
    chk("arb_err", 64'(wb_err), 64'd0);
    tick();

    // Fill the tag queue with loads to x1..x4
    for (int i = 1; i <= 4; i++) begin
      lsu_req_valid = 1'b1; lsu_req_rd = 5'(i);
      settle();
      chk("fill_rdy", 64'(lsu_req_ready), 64'd1);
      tick();
    end
    lsu_req_rd = 5'd5;
    settle();
    chk("full_rdy", 64'(lsu_req_ready), 64'd0);
    chk("full_outst", 64'(lsu_outstanding), 64'd4);
    lsu_req_valid = 1'b0;
    lsu_resp_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      lsu_resp_data = 64'h100 + 64'(i);
      tick();
      chk("drain_rd", 64'(rd), 64'(i));
      chk("drain_xrd", x_rd, 64'h100 + 64'(i));
    end
    lsu_resp_valid = 1'b0;
    chk("drain_outst", 64'(lsu_outstanding), 64'd0);
    tick();

    // WAW on x9 stalls until the cycle after the first write
    lsu_req_valid = 1'b1; lsu_req_rd = 5'd9;
    tick();
    settle();
    chk("waw_stall", 64'(lsu_req_ready), 64'd0);
    lsu_resp_valid = 1'b1; lsu_resp_data = 64'h99;
    tick();
    lsu_resp_valid = 1'b0;
    chk("waw_rd9", 64'(rd), 64'd9);
    chk("waw_no_bypass", 64'(lsu_req_ready), 64'd0);
    tick();
    chk("waw_release", 64'(lsu_req_ready), 64'd1);
    chk("waw_outst0", 64'(lsu_outstanding), 64'd0);
    tick();
    lsu_req_valid = 1'b0;
    chk("waw_outst1", 64'(lsu_outstanding), 64'd1);
    lsu_resp_valid = 1'b1; lsu_resp_data = 64'h9A;
    tick();
    lsu_resp_valid = 1'b0;
    chk("waw2_xrd", x_rd, 64'h9A);
    tick();

    // Load to x0 is drained silently
    lsu_req_valid = 1'b1; lsu_req_rd = 5'd0;
    tick();
    lsu_req_valid = 1'b0;
    rs1 = 5'd0;
    settle();
    chk("x0_busy", 64'(rs1_busy), 64'd0);
    chk("x0_outst", 64'(lsu_outstanding), 64'd1);
    lsu_resp_valid = 1'b1; lsu_resp_data = 64'hAA;
    tick();
    lsu_resp_valid = 1'b0;
    chk("x0_wen", 64'(rd_wen), 64'd0);
    chk("x0_rd_hold", 64'(rd), 64'd9);
    chk("x0_outst0", 64'(lsu_outstanding), 64'd0);

    // Orphan response sets the sticky error
    lsu_resp_valid = 1'b1; lsu_resp_data = 64'hBB;
    settle();
    chk("orph_rdy", 64'(lsu_resp_ready), 64'd0);
    tick();
    lsu_resp_valid = 1'b0;
    chk("orph_err", 64'(wb_err), 64'd1);
    chk("orph_wen", 64'(rd_wen), 64'd0);
    tick();
    chk("orph_sticky", 64'(wb_err), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("rst_clr_err", 64'(wb_err), 64'd0);
    tick();
    rst = 1'b1;
    tick();

    // ALU overwrite of a pending load register
    lsu_req_valid = 1'b1; lsu_req_rd = 5'd7;
    tick();
    lsu_req_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'h55;
    tick();
    alu_valid = 1'b0;
    chk("waw_alu_err", 64'(wb_err), 64'd1);
    chk("waw_alu_rd", 64'(rd), 64'd7);
    chk("waw_alu_xrd", x_rd, 64'h55);
    tick();

    // Async reset mid-load
    #2 rst = 1'b0;
    #1;
    rs1 = 5'd7;
    settle();
    chk("amid_rd", 64'(rd), 64'd0);
    chk("amid_xrd", x_rd, 64'd0);
    chk("amid_wen", 64'(rd_wen), 64'd0);
    chk("amid_outst", 64'(lsu_outstanding), 64'd0);
    chk("amid_err", 64'(wb_err), 64'd0);
    chk("amid_busy", 64'(rs1_busy), 64'd0);
    tick();
    rst = 1'b1;
    lsu_resp_valid = 1'b1; lsu_resp_data = 64'hCC;
    tick();
    lsu_resp_valid = 1'b0;
    chk("post_rst_err", 64'(wb_err), 64'd1);
    chk("post_rst_wen", 64'(rd_wen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
